// File: rtl/bf_tt_checker.sv
// rtl/bf_tt_checker.sv - walks a boolean-function DUT through every input vector and checks it against a truth table.
// Optional abort-on-first-mismatch behaviour is enabled with BF_CHK_STOP_ON_FAIL_EN.
module bf_tt_checker #(
    parameter int                     N_IN     = 3,
    parameter logic [(1<<N_IN)-1:0]   EXPECTED = 8'hE8,
    parameter int                     SETTLE   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   stim,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_fail_idx,
    output logic              first_fail_valid
);

    localparam int             CW        = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] STIM_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t         state;
    logic [CW-1:0]  settle_cnt;
    logic           mismatch;
    logic           last_vec;

    assign mismatch = (dut_out != EXPECTED[stim]);
    assign last_vec = (stim == STIM_LAST);

    // done/busy/pass are registered off the DONE state, so the done pulse
    // appears in the cycle after DONE and the FSM is already back in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            stim             <= '0;
            settle_cnt       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    stim       <= '0;
                    settle_cnt <= '0;
                    if (start) begin
                        state            <= S_WAIT;
                        busy             <= 1'b1;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_idx   <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (settle_cnt == CNT_LAST) begin
                        settle_cnt <= '0;
                        state      <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    settle_cnt <= '0;
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        if (!first_fail_valid) begin
                            first_fail_idx   <= stim;
                            first_fail_valid <= 1'b1;
                        end
                    end
`ifdef BF_CHK_STOP_ON_FAIL_EN
                    if (mismatch || last_vec) begin
                        state <= S_DONE;
                    end else begin
                        stim  <= stim + 1'b1;
                        state <= S_WAIT;
                    end
`else
                    if (last_vec) begin
                        state <= S_DONE;
                    end else begin
                        stim  <= stim + 1'b1;
                        state <= S_WAIT;
                    end
`endif
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (err_count == '0);
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf_tt_checker.sv
// tb/tb_bf_tt_checker.sv - table-driven scoreboard bench for bf_tt_checker.
module tb_bf_tt_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] stim;
    logic       dut_out;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [2:0] first_fail_idx;
    logic       first_fail_valid;
    int         mode = 0;

    logic       start_b = 1'b0;
    logic [0:0] stim_b;
    logic       busy_b, done_b, pass_b;
    logic [1:0] err_count_b;
    logic [0:0] first_fail_idx_b;
    logic       first_fail_valid_b;

    always #5 clk = ~clk;

    logic maj;
    assign maj = (stim[2] & stim[1]) | (stim[2] & stim[0]) | (stim[1] & stim[0]);

    always_comb begin
        dut_out = 1'b0;
        case (mode)
            0:       dut_out = maj;
            1:       dut_out = 1'b0;
            default: dut_out = ~maj;
        endcase
    end

    bf_tt_checker dut (
        .clk(clk), .rst(rst), .start(start), .stim(stim), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_idx(first_fail_idx), .first_fail_valid(first_fail_valid)
    );

    bf_tt_checker #(.N_IN(1), .EXPECTED(2'b10), .SETTLE(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stim(stim_b), .dut_out(stim_b[0]),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_count_b),
        .first_fail_idx(first_fail_idx_b), .first_fail_valid(first_fail_valid_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int mode;
        int err;
        int ffidx;
        int ffvalid;
        int pass;
        int done_c;
        int last_stim;
    } vec_t;

    vec_t tbl[3];
    vec_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Must be entered on a falling edge; the next rising edge is t0.
    task automatic start_run(input vec_t v);
        sb.push_back(v);
        mode  = v.mode;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int poke, input int restart, input vec_t nxt);
        int   c;
        vec_t e;
        for (c = 0; c < 60; c++) begin
            if (done) break;
            if (c == 0) check("busy_at_accept", busy, 1);
            if ((c % 3 == 1) && (c / 3 <= sb[0].last_stim)) check("stim_step", stim, c / 3);
            if (c == poke) start = 1'b1;
            if (c == poke + 1) start = 1'b0;
            @(negedge clk);
        end
        e = sb.pop_front();
        check("done_cycle", c, e.done_c);
        check("err_count", err_count, e.err);
        check("first_fail_idx", first_fail_idx, e.ffidx);
        check("first_fail_valid", first_fail_valid, e.ffvalid);
        check("pass", pass, e.pass);
        check("busy_at_done", busy, 0);
`ifdef BF_CHK_STOP_ON_FAIL_EN
        check("stim_at_done", stim, e.last_stim);
`endif
        if (restart != 0) begin
            sb.push_back(nxt);
            mode  = nxt.mode;
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse_width", done, 0);
        if (restart != 0) begin
            check("restart_busy", busy, 1);
            check("restart_err_cleared", err_count, 0);
            check("restart_ffv_cleared", first_fail_valid, 0);
        end
    endtask

    initial begin
        int   c;
        int   seen_done;
        vec_t rv;

        tbl[0] = '{0, 0, 0, 0, 1, 25, 7};
`ifdef BF_CHK_STOP_ON_FAIL_EN
        tbl[1] = '{1, 1, 3, 1, 0, 13, 3};
        tbl[2] = '{2, 1, 0, 1, 0, 4, 0};
`else
        tbl[1] = '{1, 4, 3, 1, 0, 25, 7};
        tbl[2] = '{2, 8, 0, 1, 0, 25, 7};
`endif

        repeat (2) @(negedge clk);
        check("rst_stim", stim, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_ffidx", first_fail_idx, 0);
        check("rst_ffv", first_fail_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        // Table runs; run 0 also pokes start while stim=4.
        for (int i = 0; i < 3; i++) begin
            start_run(tbl[i]);
            wait_done((i == 0) ? 13 : -1, 0, tbl[0]);
        end

        // Restart on the edge right after the done cycle.
        start_run(tbl[2]);
        wait_done(-1, 1, tbl[0]);
        wait_done(-1, 0, tbl[0]);

        // Async reset mid-run while stim=5.
`ifdef BF_CHK_STOP_ON_FAIL_EN
        rv = tbl[0];
`else
        rv = tbl[1];
`endif
        start_run(rv);
        repeat (16) @(negedge clk);
        check("stim_before_rst", stim, 5);
`ifdef BF_CHK_STOP_ON_FAIL_EN
        check("err_before_rst", err_count, 0);
`else
        check("err_before_rst", err_count, 1);
`endif
        rst = 1'b1;
        #1;
        check("async_rst_stim", stim, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_err", err_count, 0);
        #1;
        rst = 1'b0;
        sb.delete();
        seen_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done || busy || (stim != 3'd0)) seen_done = 1;
        end
        check("idle_after_rst", seen_done, 0);

        // Single-input checker: done at t0+5 with pass.
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (c = 0; c < 30; c++) begin
            if (done_b) break;
            @(negedge clk);
        end
        check("n1_done_cycle", c, 5);
        check("n1_pass", pass_b, 1);
        check("n1_err", err_count_b, 0);
        check("n1_ffv", first_fail_valid_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
